// File: rtl/fifo_stream_pkg.sv
// Shared types and width helpers for the FIFO drain/stream blocks.
package fifo_stream_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } burst_state_t;

    // Beat counter width; a single-beat burst still needs one bit.
    function automatic int unsigned beat_width(input int unsigned burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

    function automatic int unsigned timer_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO show-ahead read side plus valid/ready burst stream.
interface fifo_burst_reader_if #(
    parameter int unsigned WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_pop, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_pop, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO into a valid/ready stream grouped into bursts.
// A hold register decides m_last before the word becomes visible.
module fifo_burst_reader
    import fifo_stream_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic                clk,
    input  logic                rst,
    fifo_burst_reader_if.master bus,
    output logic                timeout_flush
);

    localparam int unsigned BEAT_W  = beat_width(BURST_LEN);
    localparam int unsigned TIMER_W = timer_width(TIMEOUT);
    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);

    burst_state_t       state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               last_q, last_d;
    logic               flush_q, flush_d;

    logic out_free;
    logic at_last;
    logic timer_done;
    logic move;
    logic pop;
    logic close_burst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            timer_q <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        timer_d = timer_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        flush_d = 1'b0;

        out_free    = !valid_q || bus.m_ready;
        at_last     = (beat_q == BEAT_LAST);
        timer_done  = (timer_q == TIMER_MAX);
        move        = (state_q == S_HOLD) && out_free &&
                      (at_last || !bus.fifo_empty || timer_done);
        pop         = !rst && !bus.fifo_empty && ((state_q == S_IDLE) || move);
        // A word that arrives after the timer expired keeps the burst open.
        close_burst = at_last || (bus.fifo_empty && timer_done);

        if (move) begin
            valid_d = 1'b1;
            data_d  = hold_q;
            last_d  = close_burst;
            flush_d = close_burst && !at_last;
            beat_d  = close_burst ? '0 : beat_q + 1'b1;
        end else if (valid_q && bus.m_ready) begin
            valid_d = 1'b0;
        end

        if (pop) begin
            hold_d  = bus.fifo_data;
            timer_d = '0;
        end else if ((state_q == S_HOLD) && bus.fifo_empty && !move && !timer_done) begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            S_IDLE:  if (pop) state_d = S_HOLD;
            S_HOLD:  if (move && !pop) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.fifo_pop  = pop;
    assign bus.m_valid   = valid_q;
    assign bus.m_data    = data_q;
    assign bus.m_last    = last_q;
    assign timeout_flush = flush_q;

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Downstream drain stage for `fifo_dualport`. It pops words from the FIFO's show-ahead output and presents them on a valid/ready stream grouped into bursts. Each burst is marked with `m_last`. A burst closes after `BURST_LEN` beats, or early when the FIFO stays empty for `TIMEOUT` cycles. A one-word hold register decides `m_last` before a word becomes visible, so `m_last` never changes while `m_valid` is high.

## Interface
Parameters:
- `WIDTH`, 8, data width; must match the FIFO.
- `BURST_LEN`, 4, beats per full burst; ≥1.
- `TIMEOUT`, 8, empty-FIFO cycles before a partial burst is closed; ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_data`  in  WIDTH  FIFO `data_out`; valid whenever `fifo_empty`=0.
- `fifo_pop`  out  1  FIFO `pop`; combinational; never high when `fifo_empty`=1 or `rst`=1.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts.
- `m_data`  out  WIDTH  output word.
- `m_last`  out  1  final beat of the burst.
- `timeout_flush`  out  1  one-cycle pulse when a burst is closed by timeout.

## Operation
- States:
  - S_IDLE: hold register empty.
  - S_HOLD: one word held, with `beat` (0..BURST_LEN-1) and `timer` (0..TIMEOUT, saturating).
- Internal terms:
  - `out_free` = !m_valid || m_ready.
  - `move` = S_HOLD && out_free && (beat==BURST_LEN-1 || !fifo_empty || timer==TIMEOUT).
- `fifo_pop` = !fifo_empty && (S_IDLE || move). A pop loads the hold register and clears `timer`.
- On `move`, the held word goes to the output register:
  - `m_last`=1 if beat==BURST_LEN-1, or if fifo_empty && timer==TIMEOUT.
  - Otherwise `m_last`=0.
- `beat` update:
  - Increments on each `move`.
  - Returns to 0 after a move with `m_last`=1.
  - Is a modulo-BURST_LEN counter, width $clog2(BURST_LEN) with a minimum of 1.
- `timer` update:
  - Increments each S_HOLD cycle with fifo_empty && !move.
  - Saturates at TIMEOUT.
  - Width $clog2(TIMEOUT+1).
- Expired timer with a stalled output: if a FIFO word arrives before `move`, the held word leaves with `m_last`=0 (no flush).
- `timeout_flush`=1 in the cycle a move closes a burst via the timer path (beat≠BURST_LEN-1). It is registered, so it is visible the cycle after, aligned with the first `m_valid` cycle of that word.
- Transitions:
  - S_IDLE→S_HOLD on pop.
  - S_HOLD→S_IDLE on move without pop.
  - Otherwise S_HOLD stays.
- Output register:
  - Loads on `move`.
  - `m_valid` clears on m_valid && m_ready && !move.
  - `m_data`/`m_last` are stable while m_valid && !m_ready.
- Throughput is one word per cycle while the FIFO is non-empty and `m_ready`=1.
- BURST_LEN=1: every word moves immediately with `m_last`=1; the timer is unused.

## Timing
- Reset values: m_valid=0, m_data=0, m_last=0, timeout_flush=0, state=S_IDLE, beat=0, timer=0; `fifo_pop`=0 during rst.
- Latency, pop→m_valid:
  - 2 cycles when the next FIFO word is present or beat==BURST_LEN-1.
  - Otherwise the word waits in hold until the next word arrives or TIMEOUT empty cycles elapse.
- Reset mid-burst: held and output words are discarded (the FIFO shares `rst`). The next word starts at beat 0.
- Back-pressure: at most 2 words are popped and not yet consumed (hold + output). Everything else remains in the FIFO.
- Simultaneous move and pop: the new word lands in hold and `timer` restarts at 0.

## Structure
- Shared package `fifo_stream_pkg`:
  - `burst_state_t` enum {S_IDLE, S_HOLD}.
  - Width helper constants for beat/timer.
- No sub-module: hold register, output register and counters are a single flat block. The top level instantiates `fifo_dualport` plus this block.

## Test plan
All scenarios use WIDTH=8, BURST_LEN=4, TIMEOUT=8 unless stated.
- Push 0x10..0x17 back-to-back, m_ready=1:
  - Output 0x10..0x17 in order, one per cycle after a 2-cycle initial latency.
  - m_last on 0x13 and 0x17 only; timeout_flush never asserted.
- Push 0xA0, 0xA1, then stop:
  - 0xA0 out with m_last=0.
  - 0xA1 out with m_last=1 after 8 empty cycles in hold; timeout_flush pulses once.
  - Next push starts at beat 0.
- m_ready=0 for 10 cycles with 6 words pushed:
  - fifo_pop fires exactly twice; m_data stable; 4 words remain in the FIFO.
  - After release, order is preserved with m_last on the 4th word.
- Timer expired while m_ready=0, then 0x55 pushed before m_ready rises:
  - The held word exits with m_last=0; no timeout_flush.
- rst for one cycle after 2 of 4 beats:
  - m_valid=0 next cycle; the following word is beat 0 and closes with m_last on its 4th beat.
- BURST_LEN=1, push 0x01..0x03:
  - Each word is output with m_last=1; timeout_flush is never asserted.
